spi_flash_arbiter: RTL and testbench
====================================

SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of Wishbone requesters (2..4).
REQ-002 Parameter TIMEOUT, default 4096, clk cycles allowed from slave acceptance to slave ack.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 m_cyc, m_stb, m_we  in  NREQ each  per-requester Wishbone cycle, strobe, write-enable.
REQ-006 m_adr, m_dat_mosi  in  NREQ x 32  per-requester address and write data.
REQ-007 m_stall, m_ack, m_err  out  NREQ each  per-requester stall, ack pulse, error pulse.
REQ-008 m_dat_miso  out  32  read data, shared by all requesters, valid with m_ack.
REQ-009 s_cyc, s_stb, s_we  out  1 each  slave-side cycle, strobe, write-enable to the SPI flash reader.
REQ-010 s_adr, s_dat_mosi  out  32 each  slave-side address and write data.
REQ-011 s_stall, s_ack  in  1 each  slave stall and ack.
REQ-012 s_dat_miso  in  32  slave read data.
REQ-013 grant  out  2  index of requester currently owning the slave.

Function
REQ-014 States: IDLE, ISSUE, WAIT, FLUSH.
REQ-015 IDLE: requester i is pending when m_cyc[i] && m_stb[i]; winner is the first pending index searching round-robin from (last_grant+1) mod NREQ.
REQ-016 m_stall[i] is combinational: low only in IDLE for the winner, high otherwise (incl. no winner).
REQ-017 On a winner in IDLE: latch its adr/we/dat_mosi, set grant and last_grant, go to ISSUE next cycle.
REQ-018 ISSUE: s_cyc=1, s_stb=1, s_adr/s_we/s_dat_mosi = latched values; on the cycle s_stall==0 the request is accepted, go to WAIT, clear timeout counter.
REQ-019 WAIT: s_cyc=1, s_stb=0; timeout counter increments each cycle.
REQ-020 s_ack in ISSUE-accept cycle or WAIT: register s_dat_miso to m_dat_miso, pulse m_ack[grant] one cycle later for exactly one cycle, return to IDLE.
REQ-021 m_dat_miso holds last forwarded value; reset value 0.
REQ-022 Timeout counter reaching TIMEOUT in WAIT: pulse m_err[grant] one cycle, drop s_cyc, go to FLUSH.
REQ-023 FLUSH: s_cyc=0, s_stb=0; any s_ack is discarded; go to IDLE on first cycle with s_stall==0 and s_ack==0.
REQ-024 Requester deasserting m_cyc[grant] during ISSUE/WAIT: slave transaction completes normally, s_ack consumed, m_ack suppressed.
REQ-025 Write transactions use identical sequencing (slave acks writes directly).
REQ-026 At most one of m_ack/m_err bits asserted in any cycle; never to a non-granted requester.
REQ-027 A requester granted last is skipped if another is pending (no back-to-back grant under contention).
REQ-028 Counter width $clog2(TIMEOUT)+1; saturating, no wrap.

Reset
REQ-029 rst_n low: state IDLE, last_grant NREQ-1 (so requester 0 wins first), grant 0, s_cyc/s_stb/s_we 0, s_adr/s_dat_mosi 0, m_ack/m_err 0, m_dat_miso 0, counter 0.
REQ-030 Reset mid-transaction abandons it with no ack/err; slave not notified beyond s_cyc dropping.

Structure
REQ-031 Shared package spi_arb_pkg holds state enum, NREQ_MAX=4, ADR_W=32, DAT_W=32.
REQ-032 Round-robin search is one sub-module rr_picker (pending mask, last_grant -> winner valid, winner index), purely combinational.

Verification
REQ-033 Single read: m0 requests adr 0x100000, slave acks after 20 cycles with 0xA5 -> s_adr 0x100000, m_ack[0] one cycle after s_ack, m_dat_miso 0x000000A5.
REQ-034 Contention: m0 and m1 request same cycle after reset -> grant order 0,1,0,1 over four back-to-back requests each.
REQ-035 Timeout: TIMEOUT=64, slave never acks -> m_err[grant] at cycle 64 after acceptance, s_cyc 0, FLUSH until s_stall low, then next request served.
REQ-036 Abort: m1 drops m_cyc in WAIT -> slave ack consumed, m_ack[1] never asserted, next grant proceeds.
REQ-037 Reset mid-WAIT: rst_n low 3 cycles -> all outputs at reset values, first post-reset grant to m0.
REQ-038 Write from m0 with slave immediate ack -> m_ack[0] one cycle after s_ack, no stall beyond ISSUE.

Source files
------------

// File: rtl/spi_flash_arbiter_pkg.sv
// Shared types and widths for the SPI flash Wishbone arbiter.
package spi_arb_pkg;
    localparam int NREQ_MAX = 4;
    localparam int ADR_W    = 32;
    localparam int DAT_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FLUSH = 2'd3
    } arb_state_t;
endpackage

// File: rtl/spi_flash_arbiter_rr_picker.sv
// Combinational round-robin winner search starting just after last_grant.
module rr_picker #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] pending,
    input  logic [1:0]      last_grant,
    output logic            win_valid,
    output logic [1:0]      win_idx
);
    int cand;

    // Walk from the farthest candidate to the nearest so the nearest pending one wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        cand      = 0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = int'(last_grant) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            for (int j = 0; j < NREQ; j++) begin
                if (cand == j && pending[j]) begin
                    win_valid = 1'b1;
                    win_idx   = 2'(j);
                end
            end
        end
    end
endmodule

// File: rtl/spi_flash_arbiter.sv
// Round-robin Wishbone arbiter giving NREQ requesters shared access to one SPI flash reader,
// with a slave-ack timeout and a flush phase after a timed-out transaction.
module spi_flash_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            m_cyc,
    input  logic [NREQ-1:0]            m_stb,
    input  logic [NREQ-1:0]            m_we,
    input  logic [NREQ-1:0][ADR_W-1:0] m_adr,
    input  logic [NREQ-1:0][DAT_W-1:0] m_dat_mosi,
    output logic [NREQ-1:0]            m_stall,
    output logic [NREQ-1:0]            m_ack,
    output logic [NREQ-1:0]            m_err,
    output logic [DAT_W-1:0]           m_dat_miso,
    output logic                       s_cyc,
    output logic                       s_stb,
    output logic                       s_we,
    output logic [ADR_W-1:0]           s_adr,
    output logic [DAT_W-1:0]           s_dat_mosi,
    input  logic                       s_stall,
    input  logic                       s_ack,
    input  logic [DAT_W-1:0]           s_dat_miso,
    output logic [1:0]                 grant
);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    arb_state_t       state_reg, state_next;
    logic [1:0]       grant_reg, last_grant_reg;
    logic [ADR_W-1:0] adr_reg;
    logic [DAT_W-1:0] dat_reg, miso_reg;
    logic             we_reg, abort_reg;
    logic [NREQ-1:0]  ack_reg, err_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [NREQ-1:0]  pending, grant_sel;
    logic             win_valid, grant_cyc, accept, ack_evt, abort_now, timeout_hit;
    logic [1:0]       win_idx;
    logic [ADR_W-1:0] win_adr;
    logic [DAT_W-1:0] win_dat;
    logic             win_we;

    assign pending = m_cyc & m_stb;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .pending    (pending),
        .last_grant (last_grant_reg),
        .win_valid  (win_valid),
        .win_idx    (win_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_sel
            assign grant_sel[gi] = (grant_reg == 2'(gi));
        end
    endgenerate

    always_comb begin
        win_adr = '0;
        win_dat = '0;
        win_we  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == 2'(i)) begin
                win_adr = m_adr[i];
                win_dat = m_dat_mosi[i];
                win_we  = m_we[i];
            end
        end
    end

    assign grant_cyc   = |(m_cyc & grant_sel);
    assign abort_now   = abort_reg | ~grant_cyc;
    assign accept      = (state_reg == ST_ISSUE) && !s_stall;
    assign ack_evt     = (accept || state_reg == ST_WAIT) && s_ack;
    // Error follows the TIMEOUT-th unacknowledged WAIT cycle, aligned like an ack pulse.
    assign timeout_hit = (state_reg == ST_WAIT) && !s_ack && (cnt_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (win_valid) state_next = ST_ISSUE;
            ST_ISSUE: if (!s_stall) state_next = s_ack ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                if (s_ack) begin
                    state_next = ST_IDLE;
                end else if (timeout_hit) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: if (!s_stall && !s_ack) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_cyc   = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
        s_stb   = (state_reg == ST_ISSUE);
        m_stall = '1;
        for (int i = 0; i < NREQ; i++) begin
            if (state_reg == ST_IDLE && win_valid && win_idx == 2'(i)) begin
                m_stall[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_reg      <= 2'd0;
            last_grant_reg <= 2'(NREQ - 1);
            adr_reg        <= '0;
            dat_reg        <= '0;
            we_reg         <= 1'b0;
            abort_reg      <= 1'b0;
            ack_reg        <= '0;
            err_reg        <= '0;
            miso_reg       <= '0;
            cnt_reg        <= '0;
        end else begin
            ack_reg <= '0;
            err_reg <= '0;
            if (state_reg == ST_IDLE && win_valid) begin
                grant_reg      <= win_idx;
                last_grant_reg <= win_idx;
                adr_reg        <= win_adr;
                dat_reg        <= win_dat;
                we_reg         <= win_we;
                abort_reg      <= 1'b0;
            end
            if ((state_reg == ST_ISSUE || state_reg == ST_WAIT) && !grant_cyc) begin
                abort_reg <= 1'b1;
            end
            if (accept) begin
                cnt_reg <= '0;
            end else if (state_reg == ST_WAIT && cnt_reg != '1) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            // An abandoned requester still lets the slave finish; only its ack is dropped.
            if (ack_evt && !abort_now) begin
                ack_reg  <= grant_sel;
                miso_reg <= s_dat_miso;
            end
            if (timeout_hit) begin
                err_reg <= grant_sel;
            end
        end
    end

    assign m_ack      = ack_reg;
    assign m_err      = err_reg;
    assign m_dat_miso = miso_reg;
    assign s_adr      = adr_reg;
    assign s_we       = we_reg;
    assign s_dat_mosi = dat_reg;
    assign grant      = grant_reg;
endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Scoreboard bench: requester tasks queue expected responses, monitors pop and compare.
module tb_spi_flash_arbiter;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 64;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       m_cyc = '0, m_stb = '0, m_we = '0;
    logic [NREQ-1:0][31:0] m_adr = '0, m_dat_mosi = '0;
    logic [NREQ-1:0]       m_stall, m_ack, m_err;
    logic [31:0]           m_dat_miso;
    logic                  s_cyc, s_stb, s_we;
    logic [31:0]           s_adr, s_dat_mosi;
    logic                  s_stall = 1'b0, s_ack = 1'b0;
    logic [31:0]           s_dat_miso = '0;
    logic [1:0]            grant;

    spi_flash_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_mosi(m_dat_mosi),
        .m_stall(m_stall), .m_ack(m_ack), .m_err(m_err), .m_dat_miso(m_dat_miso),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_mosi(s_dat_mosi),
        .s_stall(s_stall), .s_ack(s_ack), .s_dat_miso(s_dat_miso), .grant(grant)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit is_err; bit we; logic [31:0] data; } resp_t;
    typedef struct { int idx; logic [31:0] adr; bit we; logic [31:0] dat; int hs_cycle; } slv_t;

    resp_t resp_q[NREQ][$];
    slv_t  slv_q[$];
    int    grant_log[$];
    int    tests = 0, fails = 0;
    int    ack_cnt[NREQ];

    // slave model knobs and bookkeeping
    int          lat_min = 0, lat_max = 0, stall_pct = 0;
    bit          never_ack = 0, force_stall = 0;
    int          acc_cycle = -1000, sack_cycle = -1000, last_hs_cycle = 0;
    bit          busy = 0;
    int          scnt = 0, lat = 0;
    logic [31:0] pend_data = '0;
    slv_t        se;

    function automatic logic [31:0] slave_fn(input logic [31:0] a);
        return a ^ 32'h0010_00A5;
    endfunction

    function automatic int rr_expect(input logic [NREQ-1:0] pend, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave: random stall, ack after a random latency with address-derived data.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 0; s_ack = 0; s_stall = 0;
            end else begin
                s_ack = 0;
                if (busy) begin
                    if (scnt == 0) begin
                        s_ack = 1; s_dat_miso = pend_data; busy = 0; sack_cycle = cyc;
                    end else begin
                        scnt--;
                    end
                end
                s_stall = force_stall || ($urandom_range(99) < stall_pct);
                if (!busy && !s_ack && s_stb && !s_stall) begin
                    acc_cycle = cyc;
                    pend_data = slave_fn(s_adr);
                    if (slv_q.size() == 0) begin
                        check("slave_unexpected_accept", 32'd1, 32'd0);
                    end else begin
                        se = slv_q.pop_front();
                        check("slave_adr",   s_adr, se.adr);
                        check("slave_we",    32'(s_we), 32'(se.we));
                        check("slave_dat",   s_dat_mosi, se.dat);
                        check("slave_grant", 32'(grant), 32'(se.idx));
                        if (stall_pct == 0 && !force_stall)
                            check("issue_one_cycle", 32'(acc_cycle), 32'(se.hs_cycle + 1));
                    end
                    if (!never_ack) begin
                        lat = $urandom_range(lat_max, lat_min);
                        if (lat == 0) begin
                            s_ack = 1; s_dat_miso = pend_data; sack_cycle = cyc;
                        end else begin
                            busy = 1; scnt = lat - 1;
                        end
                    end
                end
            end
        end
    end

    // Grant monitor: each requester handshake checked against a round-robin model.
    int               model_last = NREQ - 1;
    int               nlow, hs, expw;
    logic [NREQ-1:0]  pend;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_last = NREQ - 1;
                slv_q.delete();
            end else begin
                nlow = 0; hs = -1;
                pend = m_cyc & m_stb;
                for (int i = 0; i < NREQ; i++) begin
                    if (!m_stall[i]) begin
                        nlow++;
                        if (pend[i]) hs = i;
                    end
                end
                if (nlow > 0 || pend != '0) begin
                    expw = rr_expect(pend, model_last);
                    if (nlow > 0) begin
                        check("single_unstalled", 32'(nlow), 32'd1);
                        check("rr_winner", 32'(hs), 32'(expw));
                        if (hs >= 0) begin
                            model_last = hs;
                            grant_log.push_back(hs);
                            last_hs_cycle = cyc;
                            slv_q.push_back('{hs, m_adr[hs], m_we[hs], m_dat_mosi[hs], cyc});
                        end
                    end
                end
            end
        end
    end

    // Response monitor: pops the per-requester queue on every ack/err pulse.
    resp_t re;
    int    nbits;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && (m_ack != '0 || m_err != '0)) begin
                nbits = $countones({m_ack, m_err});
                check("resp_onehot", 32'(nbits), 32'd1);
                for (int i = 0; i < NREQ; i++) begin
                    if (m_ack[i] || m_err[i]) begin
                        if (m_ack[i]) ack_cnt[i]++;
                        if (resp_q[i].size() == 0) begin
                            check($sformatf("unexpected_resp_m%0d", i), {m_err[i], m_ack[i]}, 32'd0);
                        end else begin
                            re = resp_q[i].pop_front();
                            check($sformatf("resp_is_err_m%0d", i), 32'(m_err[i]), 32'(re.is_err));
                            if (re.is_err) begin
                                check("err_timing", 32'(cyc), 32'(acc_cycle + TIMEOUT + 1));
                                check("err_s_cyc", 32'(s_cyc), 32'd0);
                            end else begin
                                check("ack_timing", 32'(cyc), 32'(sack_cycle + 1));
                                if (!re.we) check("ack_data", m_dat_miso, re.data);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic run_master(input int i, input int n, input bit rnd, input logic [31:0] adr0,
                              input bit we0, input int abort_after);
        logic [31:0] adr, dat;
        bit we, got;
        for (int r = 0; r < n; r++) begin
            adr = rnd ? $urandom : adr0 + 32'(r * 4);
            we  = rnd ? 1'($urandom_range(1, 0)) : we0;
            dat = $urandom;
            if (abort_after == 0) resp_q[i].push_back('{never_ack, we, slave_fn(adr)});
            @(posedge clk); #1;
            m_cyc[i] = 1; m_stb[i] = 1; m_we[i] = we; m_adr[i] = adr; m_dat_mosi[i] = dat;
            got = 0;
            for (int t = 0; t < 2000 && !got; t++) begin
                @(negedge clk);
                if (!m_stall[i]) got = 1;
            end
            if (!got) check($sformatf("grant_wait_m%0d", i), 32'd0, 32'd1);
            @(posedge clk); #1;
            m_stb[i] = 0;
            if (abort_after > 0) begin
                repeat (abort_after) @(posedge clk);
                #1 m_cyc[i] = 0;
            end else begin
                got = 0;
                for (int t = 0; t < 2000 && !got; t++) begin
                    @(negedge clk);
                    if (m_ack[i] || m_err[i]) got = 1;
                end
                if (!got) check($sformatf("resp_wait_m%0d", i), 32'd0, 32'd1);
                @(posedge clk); #1;
                m_cyc[i] = 0;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_cyc"}, 32'(s_cyc), 32'd0);
        check({tag, "_s_stb"}, 32'(s_stb), 32'd0);
        check({tag, "_s_we"}, 32'(s_we), 32'd0);
        check({tag, "_s_adr"}, s_adr, 32'd0);
        check({tag, "_s_dat_mosi"}, s_dat_mosi, 32'd0);
        check({tag, "_m_ack_err"}, 32'({m_ack, m_err}), 32'd0);
        check({tag, "_m_dat_miso"}, m_dat_miso, 32'd0);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_m_stall"}, 32'(m_stall), 32'((1 << NREQ) - 1));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs(tag);
        for (int i = 0; i < NREQ; i++) resp_q[i].delete();
        rst_n = 1;
    endtask

    int ack1_before, rel_cycle;
    bit seen;

    initial begin
        // Reset state, then contention straight out of reset.
        do_reset("reset");
        repeat (2) @(negedge clk);
        lat_min = 2; lat_max = 2; stall_pct = 0;
        grant_log.delete();
        fork
            run_master(0, 4, 0, 32'h0000_1000, 0, 0);
            run_master(1, 4, 0, 32'h0000_2000, 0, 0);
        join
        check("contention_count", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++)
            check($sformatf("contention_order_%0d", k), 32'(grant_log[k]), 32'(k % 2));

        // Single read, 20-cycle slave latency.
        lat_min = 20; lat_max = 20;
        run_master(0, 1, 0, 32'h0010_0000, 0, 0);
        check("single_read_data", m_dat_miso, 32'h0000_00A5);

        // Write with immediate slave ack.
        lat_min = 0; lat_max = 0;
        run_master(0, 1, 0, 32'h0000_0200, 1, 0);

        // Requester 1 abandons its cycle in WAIT.
        lat_min = 20; lat_max = 20;
        ack1_before = ack_cnt[1];
        run_master(1, 1, 0, 32'h0000_3000, 0, 5);
        repeat (30) @(negedge clk);
        check("abort_no_ack", 32'(ack_cnt[1]), 32'(ack1_before));
        lat_min = 1; lat_max = 3;
        run_master(0, 1, 0, 32'h0000_3100, 0, 0);

        // Timeout, flush held by slave stall, then a fresh request.
        never_ack = 1;
        fork
            run_master(0, 1, 0, 32'h0000_4000, 0, 0);
            begin
                seen = 0;
                for (int t = 0; t < 500 && !seen; t++) begin
                    @(negedge clk);
                    if (s_cyc && !s_stb) seen = 1;
                end
                check("timeout_reach_wait", 32'(seen), 32'd1);
                force_stall = 1;
            end
        join
        never_ack = 0;
        fork
            run_master(1, 1, 0, 32'h0000_5000, 0, 0);
            begin
                repeat (6) @(posedge clk);
                #1 force_stall = 0;
                rel_cycle = cyc;
            end
        join
        check("flush_held_until_unstall", 32'(last_hs_cycle > rel_cycle), 32'd1);

        // Reset in the middle of WAIT.
        lat_min = 30; lat_max = 30;
        @(posedge clk); #1;
        m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 32'h0000_6000; m_we[0] = 0;
        repeat (2) @(posedge clk);
        #1 m_stb[0] = 0;
        repeat (5) @(posedge clk);
        check("pre_reset_in_wait", 32'({s_cyc, s_stb}), 32'b10);
        do_reset("midwait");
        m_cyc[0] = 0;
        lat_min = 1; lat_max = 4;
        grant_log.delete();
        fork
            run_master(0, 1, 0, 32'h0000_7000, 0, 0);
            run_master(1, 1, 0, 32'h0000_8000, 0, 0);
        join
        check("post_reset_first_grant", grant_log.size() > 0 ? 32'(grant_log[0]) : 32'hFFFF_FFFF, 32'd0);

        // Randomized traffic under contention and random stall/latency.
        lat_min = 0; lat_max = 12; stall_pct = 30;
        fork
            run_master(0, 15, 1, 32'h0, 0, 0);
            run_master(1, 15, 1, 32'h0, 0, 0);
        join
        stall_pct = 0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < NREQ; i++)
            check($sformatf("resp_q_empty_m%0d", i), 32'(resp_q[i].size()), 32'd0);
        check("slave_q_empty", 32'(slv_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (tests %0d failed %0d)", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule
